alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester arbiter and sequencer for the shared `ALU`. It accepts operations from two independent clients over valid/ready handshakes and grants the ALU round-robin. It holds the operands and opcode stable on the ALU inputs for the ALU's fixed pipeline latency, then captures the result and returns it to the winning client over a valid/ready response channel. It sits between the ALU and its clients (e.g. a control FSM and a test/DMA port), so that only one operation is in flight at any time.

## Interface
Parameters:
- `WIDTH`, 32: data width, matches the ALU.
- `ALU_LAT`, 3: rising edges from operand launch to a valid `alu_r1`/flags sample; must be ≥1. The default of 3 covers the two-stage registered ALU.

Ports:
- Clocking and reset:
  - `clk` in 1: single clock; all state on its rising edge.
  - `rst_n` in 1: reset, asynchronous and active-low.
- Request channel, x = 0, 1:
  - `reqx_valid` in 1: request valid.
  - `reqx_ready` out 1: request accepted this cycle.
  - `reqx_op` in 3: ALU opcode.
  - `reqx_a` in WIDTH: operand to ALU `R2`.
  - `reqx_b` in WIDTH: operand to ALU `R3`.
- Response channel, x = 0, 1:
  - `rspx_valid` out 1: result valid.
  - `rspx_ready` in 1: client accepts result.
  - `rspx_data` out WIDTH: ALU result.
  - `rspx_flags` out 3: {overflow, carry, zero}.
- ALU side:
  - `alu_r2` out WIDTH, `alu_r3` out WIDTH, `alu_op` out 3: registered drive to the ALU.
  - `alu_r1` in WIDTH, `alu_zero` in 1, `alu_carry` in 1, `alu_overflow` in 1: sampled from the ALU.
- Status:
  - `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If any `reqx_valid` is high, the arbiter picks a winner and drives its `reqx_ready`=1 combinationally. The handshake completes in that cycle.
  - Operands and opcode load into the `alu_*` registers, `gnt_id` records the winner, `lat_cnt` loads ALU_LAT-1, and the FSM goes to WAIT.
- **Arbitration**
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins. The pointer updates on each grant.
  - After reset the pointer favours req0.
- **WAIT**
  - `alu_*` outputs are held constant.
  - `lat_cnt` decrements each cycle.
  - On the edge where `lat_cnt`==0: `alu_r1` and flags are captured into the response register, `rsp[gnt_id]_valid` is set, and the FSM goes to RESP.
- **RESP**
  - `rsp[gnt_id]_valid`, data and flags are held until `rsp[gnt_id]_ready`=1. That cycle completes the transfer: valid clears and the FSM goes to IDLE.
  - The other response channel stays 0.
- Request rules:
  - `reqx_ready` is 0 outside IDLE.
  - Requests must hold valid and payload stable until ready. No request is ever dropped.
- Opcodes 0–7 are passed through unchanged; all are legal.
- `rspx_data` is exactly `alu_r1`; no width change.
- Reset values (async, `rst_n`=0):
  - FSM is IDLE; `lat_cnt`=0; pointer favours req0.
  - All `reqx_ready`=0 and `rspx_valid`=0.
  - `rspx_data`, `rspx_flags`, `alu_r2`, `alu_r3` and `alu_op` are all 0.
  - `busy`=0.
- Reset mid-operation: any in-flight operation and any pending response are discarded without notification. Clients re-request after reset release.

## Timing
- Handshake in cycle 0, with `alu_*` updated at edge 1.
- `rspx_valid` rises at edge 1+ALU_LAT. With the default ALU_LAT=3, `rspx_valid` is visible in cycle 4.
- If `rspx_ready` is held high, the FSM returns to IDLE after edge 2+ALU_LAT. Next handshake is possible in cycle ALU_LAT+2.
- Peak throughput is one operation per ALU_LAT+2 cycles.
- A new request arriving while busy waits; its ready is first asserted in the IDLE cycle after the response completes.

## Configuration
- Macro `ALU_SHARE_FLAGS_EN`.
  - Defined: `rspx_flags` carries the captured `alu_overflow`, `alu_carry` and `alu_zero`.
  - Undefined: flag inputs are unused, no flag registers are built, and `rspx_flags` is tied to 3'b000.

## Structure
- Shared package `alu_ctrl_pkg`:
  - Opcode constants: OP_PASS=0, OP_NOT=1, OP_ADD=2, OP_NOR=3, OP_SUB=4, OP_NAND=5, OP_AND=6, OP_SLT=7.
  - FSM state typedef.
  - Flag bit indices (OVF=2, CARRY=1, ZERO=0).
- Sub-module `rr_arbiter2`: two-way round-robin with grant-update input. It outputs a one-hot grant and holds the last-grant pointer.

## Test plan
- **Single ADD:** req0 ADD a=5, b=7, other side idle → `rsp0_valid` in cycle 4, `rsp0_data`=12, flags=000, `rsp1_valid` stays 0.
- **Contention:** after reset, req0 SUB (9−4) and req1 AND (0xF0 & 0x3C) both valid.
  - req0 is granted first and returns 5.
  - req1 is granted next and returns 0x30.
  - A second simultaneous pair is granted req1 first.
- **Flags:** SUB 0x80000000−1 with `ALU_SHARE_FLAGS_EN` → data 0x7FFFFFFF and overflow flag=1. Without the macro, flags are 000.
- **Backpressure:** `rsp0_ready`=0 for 5 cycles → `rsp0_valid`, data and flags are stable, `req1_ready` stays 0 despite `req1_valid`=1, and req1 is granted one cycle after `rsp0_ready` rises.
- **Reset in WAIT:** assert `rst_n`=0 one cycle after handshake → all outputs return to reset values immediately and no response is issued. After release, a req1-only request is granted in the first IDLE cycle.
- **Back-to-back single requester:** req1 issues 3 consecutive NOR ops → each is granted without waiting on req0, and handshakes are spaced ALU_LAT+2 cycles apart.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU sharing controller:
// opcodes, sequencer states and response flag bit positions.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_AND  = 3'd6;
  localparam logic [2:0] OP_SLT  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int FLG_OVF   = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_ZERO  = 0;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant,
// tie goes to the side not granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  // prio_q = 1 means req1 wins a tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (upd_i && (|gnt_o)) begin
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between two clients, one op in flight.
// Define ALU_SHARE_FLAGS_EN to return {overflow, carry, zero} with results.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic [2:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [2:0]       rsp1_flags,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r1,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAT_LD  = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] LAT_ONE = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    lat_q, lat_d;
  logic             gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] r3_q, r3_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       rv_q, rv_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [1:0] req_v;
  logic [1:0] gnt;
  logic [1:0] rdy;
  logic       hs;
  logic       rsp_rdy;
  logic       lat_zero;

  assign req_v    = {req1_valid, req0_valid};
  assign hs       = (state_q == S_IDLE) && (|req_v);
  assign rsp_rdy  = gnt_id_q ? rsp1_ready : rsp0_ready;
  assign lat_zero = (lat_q == '0);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_v),
    .upd_i (hs),
    .gnt_o (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      gnt_id_q <= 1'b0;
      r2_q     <= '0;
      r3_q     <= '0;
      op_q     <= '0;
      rv_q     <= 2'b00;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      gnt_id_q <= gnt_id_d;
      r2_q     <= r2_d;
      r3_q     <= r3_d;
      op_q     <= op_d;
      rv_q     <= rv_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hs) state_d = S_WAIT;
      S_WAIT:  if (lat_zero) state_d = S_RESP;
      S_RESP:  if (rsp_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r2_d     = r2_q;
    r3_d     = r3_q;
    op_d     = op_q;
    gnt_id_d = gnt_id_q;
    lat_d    = lat_q;
    rv_d     = rv_q;
    data_d   = data_q;
    if (hs) begin
      gnt_id_d = gnt[1];
      lat_d    = LAT_LD;
      unique case (1'b1)
        gnt[1]: begin
          r2_d = req1_a;
          r3_d = req1_b;
          op_d = req1_op;
        end
        default: begin
          r2_d = req0_a;
          r3_d = req0_b;
          op_d = req0_op;
        end
      endcase
    end
    // ALU output is sampled on the edge the countdown expires
    if (state_q == S_WAIT) begin
      if (lat_zero) begin
        rv_d   = onehot2(gnt_id_q);
        data_d = alu_r1;
      end else begin
        lat_d = lat_q - LAT_ONE;
      end
    end
    if ((state_q == S_RESP) && rsp_rdy) begin
      rv_d = 2'b00;
    end
  end

  always_comb begin
    rdy = 2'b00;
    if ((state_q == S_IDLE) && rst_n) begin
      rdy = gnt;
    end
    busy = (state_q != S_IDLE);
  end

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign rsp0_valid = rv_q[0];
  assign rsp1_valid = rv_q[1];
  assign rsp0_data  = rv_q[0] ? data_q : '0;
  assign rsp1_data  = rv_q[1] ? data_q : '0;
  assign alu_r2     = r2_q;
  assign alu_r3     = r3_q;
  assign alu_op     = op_q;

`ifdef ALU_SHARE_FLAGS_EN
  logic [2:0] flg_q, flg_d;

  always_comb begin
    flg_d = flg_q;
    if ((state_q == S_WAIT) && lat_zero) begin
      flg_d[FLG_OVF]   = alu_overflow;
      flg_d[FLG_CARRY] = alu_carry;
      flg_d[FLG_ZERO]  = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flg_q <= 3'b000;
    end else begin
      flg_q <= flg_d;
    end
  end

  assign rsp0_flags = rv_q[0] ? flg_q : 3'b000;
  assign rsp1_flags = rv_q[1] ? flg_q : 3'b000;
`else
  logic unused_flags;
  assign unused_flags = alu_overflow ^ alu_carry ^ alu_zero;
  assign rsp0_flags   = 3'b000;
  assign rsp1_flags   = 3'b000;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a 2-stage registered ALU model.
// Flag expectations follow ALU_SHARE_FLAGS_EN.
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]   req_op [2];
  logic [W-1:0] req_a [2];
  logic [W-1:0] req_b [2];
  logic [W-1:0] rsp_data [2];
  logic [2:0]   rsp_flags [2];
  logic [W-1:0] alu_r2_w, alu_r3_w, alu_r1_w;
  logic [2:0]   alu_op_w;
  logic         alu_z_w, alu_c_w, alu_v_w, busy_w;

  alu_share_ctrl #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req_valid[0]),
    .req0_ready   (req_ready[0]),
    .req0_op      (req_op[0]),
    .req0_a       (req_a[0]),
    .req0_b       (req_b[0]),
    .req1_valid   (req_valid[1]),
    .req1_ready   (req_ready[1]),
    .req1_op      (req_op[1]),
    .req1_a       (req_a[1]),
    .req1_b       (req_b[1]),
    .rsp0_valid   (rsp_valid[0]),
    .rsp0_ready   (rsp_ready[0]),
    .rsp0_data    (rsp_data[0]),
    .rsp0_flags   (rsp_flags[0]),
    .rsp1_valid   (rsp_valid[1]),
    .rsp1_ready   (rsp_ready[1]),
    .rsp1_data    (rsp_data[1]),
    .rsp1_flags   (rsp_flags[1]),
    .alu_r2       (alu_r2_w),
    .alu_r3       (alu_r3_w),
    .alu_op       (alu_op_w),
    .alu_r1       (alu_r1_w),
    .alu_zero     (alu_z_w),
    .alu_carry    (alu_c_w),
    .alu_overflow (alu_v_w),
    .busy         (busy_w)
  );

  // returns {ovf, carry, zero, result}
  function automatic logic [W+2:0] alu_model(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_PASS: r = a;
      OP_NOT:  r = ~a;
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_NOR:  r = ~(a | b);
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_NAND: r = ~(a & b);
      OP_AND:  r = a & b;
      default: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
    endcase
    return {v, c, (r == '0), r};
  endfunction

  logic [W+2:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= alu_model(alu_op_w, alu_r2_w, alu_r3_w);
    pipe2 <= pipe1;
  end
  assign alu_r1_w = pipe2[W-1:0];
  assign alu_v_w  = pipe2[W+2];
  assign alu_c_w  = pipe2[W+1];
  assign alu_z_w  = pipe2[W];

  function automatic logic [2:0] fl_exp(input logic [2:0] f);
`ifdef ALU_SHARE_FLAGS_EN
    return f;
`else
    return f & 3'b000;
`endif
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  // one isolated operation; DUT must be idle on entry
  task automatic run_op(input int s, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic [2:0] f,
                        output int lat, output int wt, output bit other);
    req_op[s] = op; req_a[s] = a; req_b[s] = b;
    req_valid[s] = 1'b1;
    rsp_ready[s] = 1'b1;
    #1;
    wt = 0;
    while (!req_ready[s] && wt < 20) begin
      tick();
      wt++;
    end
    tick();
    req_valid[s] = 1'b0;
    lat = 1;
    other = 1'b0;
    while (!rsp_valid[s] && lat < 20) begin
      other |= rsp_valid[1-s];
      tick();
      lat++;
    end
    other |= rsp_valid[1-s];
    d = rsp_data[s];
    f = rsp_flags[s];
    tick();
    rsp_ready[s] = 1'b0;
  endtask

  typedef struct {
    int         side;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic [2:0] f;
  } vec_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  req_t rq0[$];
  req_t rq1[$];
  int   glog[$];
  int   hlog[$];
  logic [W-1:0] dlog[$];

  // transaction-level model: one op outstanding, tie goes to the side
  // not granted last, result visible LAT+1 cycles after the handshake
  task automatic run_engine(input int max_cyc, input bit rnd);
    bit [1:0]     pres;
    req_t         cur [2];
    int           fav, out_s, out_hs, w;
    bit           out_v, fin;
    logic [W+2:0] out_e;
    logic [1:0]   exp_rdy, exp_rv;
    pres = 2'b00; fav = 0; out_v = 1'b0; out_s = 0; out_hs = 0;
    out_e = '0; fin = 1'b0; w = 0;
    glog.delete(); hlog.delete(); dlog.delete();
    for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pres[s] && (!rnd || $urandom_range(0, 3) != 0)) begin
          if (s == 0 && rq0.size() > 0) begin
            cur[0] = rq0.pop_front();
            pres[0] = 1'b1;
          end else if (s == 1 && rq1.size() > 0) begin
            cur[1] = rq1.pop_front();
            pres[1] = 1'b1;
          end
        end
        req_valid[s] = pres[s];
        if (pres[s]) begin
          req_op[s] = cur[s].op;
          req_a[s]  = cur[s].a;
          req_b[s]  = cur[s].b;
        end
        rsp_ready[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      exp_rdy = 2'b00;
      if (!out_v && pres != 2'b00) begin
        if (pres == 2'b11) w = fav;
        else w = pres[1] ? 1 : 0;
        exp_rdy[w] = 1'b1;
      end
      exp_rv = 2'b00;
      if (out_v && cyc >= out_hs + 1 + LAT) exp_rv[out_s] = 1'b1;
      chk("eng_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("eng_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv != 2'b00) begin
        chk("eng_rsp_data", 64'(rsp_data[out_s]), 64'(out_e[W-1:0]));
        chk("eng_rsp_flags", 64'(rsp_flags[out_s]),
            64'(fl_exp(out_e[W+2:W])));
      end
      if (exp_rdy != 2'b00) begin
        out_v = 1'b1; out_s = w; out_hs = cyc;
        out_e = alu_model(cur[w].op, cur[w].a, cur[w].b);
        fav = 1 - w;
        pres[w] = 1'b0;
        glog.push_back(w);
        hlog.push_back(cyc);
      end else if (exp_rv != 2'b00 && rsp_ready[out_s]) begin
        out_v = 1'b0;
        dlog.push_back(rsp_data[out_s]);
      end
      fin = !out_v && pres == 2'b00 && rq0.size() == 0 && rq1.size() == 0;
      if (!fin) tick();
    end
    chk("eng_drain", 64'(fin), 64'(1));
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
  endtask

  vec_t         tbl [12];
  logic [W-1:0] d;
  logic [2:0]   f;
  int           lat, wt, n;
  bit           other;
  logic [W-1:0] hold_d;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, OP_ADD,  32'd5,        32'd7,        32'd12,       3'b000};
    tbl[1]  = '{1, OP_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        3'b011};
    tbl[2]  = '{0, OP_SUB,  32'd9,        32'd4,        32'd5,        3'b010};
    tbl[3]  = '{1, OP_AND,  32'hF0,       32'h3C,       32'h30,       3'b000};
    tbl[4]  = '{0, OP_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 3'b110};
    tbl[5]  = '{1, OP_NOR,  32'd0,        32'd0,        32'hFFFFFFFF, 3'b000};
    tbl[6]  = '{0, OP_NOT,  32'hFFFFFFFF, 32'd0,        32'd0,        3'b001};
    tbl[7]  = '{1, OP_PASS, 32'h1234,     32'h55,       32'h1234,     3'b000};
    tbl[8]  = '{0, OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        3'b001};
    tbl[9]  = '{1, OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        3'b000};
    tbl[10] = '{0, OP_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 3'b000};
    tbl[11] = '{1, OP_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 3'b100};

    // reset values, with both requests valid during reset
    rst_n = 1'b0;
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    for (int s = 0; s < 2; s++) begin
      req_op[s] = OP_ADD; req_a[s] = 32'hAA; req_b[s] = 32'h55;
    end
    @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_w), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp0_data", 64'(rsp_data[0]), 64'(0));
    chk("rst_rsp1_data", 64'(rsp_data[1]), 64'(0));
    chk("rst_rsp0_flags", 64'(rsp_flags[0]), 64'(0));
    chk("rst_rsp1_flags", 64'(rsp_flags[1]), 64'(0));
    chk("rst_alu_r2", 64'(alu_r2_w), 64'(0));
    chk("rst_alu_r3", 64'(alu_r3_w), 64'(0));
    chk("rst_alu_op", 64'(alu_op_w), 64'(0));
    apply_reset();

    // table of isolated operations
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].side, tbl[i].op, tbl[i].a, tbl[i].b, d, f, lat, wt, other);
      chk($sformatf("vec%0d_data", i), 64'(d), 64'(tbl[i].d));
      chk($sformatf("vec%0d_flags", i), 64'(f), 64'(fl_exp(tbl[i].f)));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT + 1));
      chk($sformatf("vec%0d_grant_wait", i), 64'(wt), 64'(0));
      chk($sformatf("vec%0d_other_rsp", i), 64'(other), 64'(0));
    end

    // contention: req0 first, then req1 beats req0's next op
    apply_reset();
    rq0.push_back('{OP_SUB, 32'd9, 32'd4});
    rq0.push_back('{OP_ADD, 32'd1, 32'd2});
    rq1.push_back('{OP_AND, 32'hF0, 32'h3C});
    run_engine(200, 1'b0);
    chk("cont_ngrants", 64'(glog.size()), 64'(3));
    if (glog.size() == 3 && dlog.size() == 3) begin
      chk("cont_g0", 64'(glog[0]), 64'(0));
      chk("cont_g1", 64'(glog[1]), 64'(1));
      chk("cont_g2", 64'(glog[2]), 64'(0));
      chk("cont_d0", 64'(dlog[0]), 64'(5));
      chk("cont_d1", 64'(dlog[1]), 64'(32'h30));
      chk("cont_d2", 64'(dlog[2]), 64'(3));
    end

    // back-to-back NOR ops from req1 alone
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      rq1.push_back('{OP_NOR, 32'(i), 32'h0F0F0000});
    end
    run_engine(200, 1'b0);
    chk("b2b_ngrants", 64'(hlog.size()), 64'(3));
    if (hlog.size() == 3) begin
      chk("b2b_gap0", 64'(hlog[1] - hlog[0]), 64'(LAT + 2));
      chk("b2b_gap1", 64'(hlog[2] - hlog[1]), 64'(LAT + 2));
      chk("b2b_side", 64'(glog[0] + glog[1] + glog[2]), 64'(3));
    end

    // backpressure on rsp0 while req1 waits
    apply_reset();
    req_op[0] = OP_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
    req_valid = 2'b01;
    #1;
    chk("bp_grant0", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid[0] = 1'b0;
    req_op[1] = OP_AND; req_a[1] = 32'hF0; req_b[1] = 32'h3C;
    req_valid[1] = 1'b1;
    #1;
    for (int k = 1; k < LAT + 1; k++) begin
      chk("bp_req1_blocked_wait", 64'(req_ready), 64'(0));
      tick();
    end
    hold_d = rsp_data[0];
    chk("bp_first_data", 64'(hold_d), 64'(12));
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      chk("bp_rsp_data", 64'(rsp_data[0]), 64'(12));
      chk("bp_rsp_flags", 64'(rsp_flags[0]), 64'(fl_exp(3'b000)));
      chk("bp_req1_blocked", 64'(req_ready), 64'(0));
      tick();
    end
    rsp_ready[0] = 1'b1;
    #1;
    chk("bp_release_valid", 64'(rsp_valid), 64'(2'b01));
    chk("bp_release_ready", 64'(req_ready), 64'(0));
    tick();
    rsp_ready[0] = 1'b0;
    #1;
    chk("bp_after_valid", 64'(rsp_valid), 64'(0));
    chk("bp_req1_grant", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    n = 0;
    while (!rsp_valid[1] && n < 10) begin
      tick();
      n++;
    end
    chk("bp_req1_latency", 64'(n), 64'(LAT));
    chk("bp_req1_data", 64'(rsp_data[1]), 64'(32'h30));
    tick();
    rsp_ready = 2'b00;

    // reset while waiting on the ALU
    apply_reset();
    req_op[0] = OP_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    #1;
    chk("rw_grant0", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = 2'b00;
    chk("rw_busy", 64'(busy_w), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rw_rst_busy", 64'(busy_w), 64'(0));
    chk("rw_rst_alu_r2", 64'(alu_r2_w), 64'(0));
    chk("rw_rst_alu_op", 64'(alu_op_w), 64'(0));
    chk("rw_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    req_op[1] = OP_AND; req_a[1] = 32'hF0; req_b[1] = 32'h3C;
    req_valid[1] = 1'b1;
    #1;
    chk("rw_req1_grant", 64'(req_ready), 64'(2'b10));
    tick();
    req_valid[1] = 1'b0;
    other = 1'b0;
    n = 0;
    while (!rsp_valid[1] && n < 10) begin
      other |= rsp_valid[0];
      tick();
      n++;
    end
    chk("rw_no_rsp0", 64'(other), 64'(0));
    chk("rw_req1_latency", 64'(n), 64'(LAT));
    chk("rw_req1_data", 64'(rsp_data[1]), 64'(32'h30));
    tick();
    rsp_ready = 2'b00;

    // randomized traffic on both clients with random backpressure
    apply_reset();
    for (int i = 0; i < 25; i++) begin
      rq0.push_back('{3'($urandom_range(0, 7)), $urandom, $urandom});
      rq1.push_back('{3'($urandom_range(0, 7)), $urandom, $urandom});
    end
    run_engine(4000, 1'b1);
    chk("rnd_ngrants", 64'(glog.size()), 64'(50));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
